// File: rtl/axis_pkt_pkg.sv
// Shared types, parameter defaults and header slicing helper for the packet emitter.
package axis_pkt_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_HDR_BEATS = 4;
  localparam int DEF_LEN_W     = 8;

  // Upper bounds for the width-generic helper below.
  localparam int MAX_DATA_W = 64;
  localparam int MAX_HDR_W  = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  // Beat idx of a header of 'beats' slices of 'dw' bits; beat 0 is the MSB slice.
  function automatic logic [MAX_DATA_W-1:0] hdr_beat(input logic [MAX_HDR_W-1:0] hdr,
                                                     input int idx,
                                                     input int beats,
                                                     input int dw);
    logic [MAX_HDR_W-1:0] sh;
    sh = hdr >> ((beats - 1 - idx) * dw);
    return sh[MAX_DATA_W-1:0] & ({MAX_DATA_W{1'b1}} >> (MAX_DATA_W - dw));
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Registered AXI-Stream output stage: a new beat enters only when the slot is empty or draining.
module axis_out_reg
  import axis_pkt_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              user_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              load_o,
  output logic [DATA_W-1:0] tdata_o,
  output logic              tvalid_o,
  output logic              tuser_o,
  output logic              tlast_o
);

  logic              vld_q;
  logic [DATA_W-1:0] data_q;
  logic              user_q;
  logic              last_q;

  assign load_o = !vld_q || ready_i;

  // Payload fields only change on a push, so they stay put across stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      user_q <= 1'b0;
      last_q <= 1'b0;
    end else if (load_o) begin
      vld_q <= push_i;
      if (push_i) begin
        data_q <= data_i;
        user_q <= user_i;
        last_q <= last_i;
      end
    end
  end

  assign tdata_o  = data_q;
  assign tvalid_o = vld_q;
  assign tuser_o  = user_q;
  assign tlast_o  = last_q;

endmodule

// File: rtl/axis_packet_emitter.sv
// Serialises a header word and a counted payload stream into one AXI-Stream packet.
module axis_packet_emitter
  import axis_pkt_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int HDR_BEATS = DEF_HDR_BEATS,
  parameter int LEN_W     = DEF_LEN_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hdr_valid,
  output logic                        hdr_ready,
  input  logic [HDR_BEATS*DATA_W-1:0] hdr_data,
  input  logic [LEN_W-1:0]            payload_len,
  input  logic [DATA_W-1:0]           s_tdata,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  output logic [DATA_W-1:0]           m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic                        m_tuser,
  output logic                        m_tlast,
  output logic                        busy
);

  localparam int IDX_W = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;

  state_e                      state_q, state_d;
  logic [HDR_BEATS*DATA_W-1:0] hdr_q, hdr_d;
  logic [LEN_W-1:0]            len_q, len_d;
  logic [LEN_W-1:0]            rem_q, rem_d;
  logic [IDX_W-1:0]            idx_q, idx_d;

  logic              load;
  logic              push;
  logic [DATA_W-1:0] p_data;
  logic              p_user, p_last;
  logic              hdr_rdy_c, s_rdy_c;

  // In IDLE the beat comes straight from the offered header; later from the latched copy.
  logic [MAX_DATA_W-1:0] beat_w;
  int                    beat_idx;
  assign beat_idx = (state_q == IDLE) ? 0 : int'(idx_q);
  assign beat_w   = hdr_beat(MAX_HDR_W'((state_q == IDLE) ? hdr_data : hdr_q),
                             beat_idx, HDR_BEATS, DATA_W);

  generate
    if (DATA_W < MAX_DATA_W) begin : g_beat_pad
      logic unused_pad;
      assign unused_pad = ^beat_w[MAX_DATA_W-1:DATA_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    len_d     = len_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    push      = 1'b0;
    p_data    = '0;
    p_user    = 1'b0;
    p_last    = 1'b0;
    hdr_rdy_c = 1'b0;
    s_rdy_c   = 1'b0;
    case (state_q)
      IDLE: begin
        hdr_rdy_c = load;
        if (hdr_valid && load) begin
          push   = 1'b1;
          p_data = beat_w[DATA_W-1:0];
          p_user = 1'b1;
          p_last = (HDR_BEATS == 1) && (payload_len == '0);
          hdr_d  = hdr_data;
          len_d  = payload_len;
          rem_d  = payload_len;
          idx_d  = IDX_W'(1);
          if (HDR_BEATS > 1)            state_d = HDR;
          else if (payload_len != '0)   state_d = PAYLOAD;
        end
      end
      HDR: begin
        if (load) begin
          push   = 1'b1;
          p_data = beat_w[DATA_W-1:0];
          idx_d  = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(HDR_BEATS - 1)) begin
            p_last  = (len_q == '0);
            state_d = (len_q != '0) ? PAYLOAD : IDLE;
          end
        end
      end
      PAYLOAD: begin
        s_rdy_c = load;
        if (s_tvalid && load) begin
          push   = 1'b1;
          p_data = s_tdata;
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            p_last  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready strobes are forced low while reset is held so every output reads 0 then.
  assign hdr_ready = rst && hdr_rdy_c;
  assign s_tready  = rst && s_rdy_c;
  assign busy      = (state_q != IDLE) || m_tvalid;

  axis_out_reg #(.DATA_W(DATA_W)) u_out (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push),
    .data_i   (p_data),
    .user_i   (p_user),
    .last_i   (p_last),
    .ready_i  (m_tready),
    .load_o   (load),
    .tdata_o  (m_tdata),
    .tvalid_o (m_tvalid),
    .tuser_o  (m_tuser),
    .tlast_o  (m_tlast)
  );

endmodule
